sel_scanner: RTL and testbench
==============================

# sel_scanner

Sequencing stage that drives the 2-bit `sel` of the 4:1 select mux and consumes its 1-bit `out`. It steps `sel` through 0,1,2,3, holds each value for a programmable dwell, samples the mux output at the end of each slot, and assembles the four samples into a 4-bit parallel word with a one-cycle `valid` strobe. It supports single-shot and continuous scanning, and is the only block that drives the mux select.

## Interface
- `DWELL`, default 4: cycles per slot, legal range 1..255.
- `CW`, default 8: dwell counter width; must satisfy 2^CW > DWELL.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a scan; sampled only in IDLE.
- `cont` in 1: continuous mode, sampled with `start`; rescan until `stop`.
- `stop` in 1: end continuous mode after the current scan completes.
- `din` in 1: mux output `out`.
- `sel` out 2: mux select.
- `data` out 4: assembled word; `data[k]` = sample taken with `sel==k`.
- `valid` out 1: one-cycle strobe when `data` updates.
- `busy` out 1: high while a scan is in progress.

## Operation
- States:
  - IDLE: `busy`=0, `sel`=0.
  - SCAN: dwell counter `cnt` runs 0..DWELL-1 per slot.
- IDLE -> SCAN on `start`=1: `sel`<=0, `cnt`<=0, `busy`<=1, and the `cont_r`<=`cont` latch is loaded.
- In SCAN, each cycle with `cnt`==DWELL-1:
  - `shreg[sel]`<=`din`, `cnt`<=0, `sel`<=`sel`+1 (2-bit wrap).
- Otherwise in SCAN: `cnt`<=`cnt`+1.
- Scan end is the last-cycle sample with `sel`==3:
  - `data`<={`din`, `shreg[2:0]`} (the current sample is bypassed in directly).
  - `valid`<=1; `sel`<=0.
  - If `cont_r` is set and `stop` has not been seen, stay in SCAN (new scan starts immediately, no gap). Otherwise go to IDLE with `busy`<=0.
- `stop` may arrive at any cycle in SCAN. It sets a sticky `stop_r` flag, cleared on entry to IDLE. It never truncates a scan in progress.
- `start` in SCAN is ignored.
- `start` in the same cycle as a scan-end transition to IDLE is ignored; the request must be re-asserted.
- `data` holds its value until the next completed scan. Partial scans never reach `data`.
- `cnt` width is CW; no arithmetic beyond an increment and a compare to DWELL-1.

## Timing
- Reset values (asynchronous, immediate): `sel`=0, `data`=0, `valid`=0, `busy`=0, state IDLE, `cnt`=0, `shreg`=0, `cont_r`=0, `stop_r`=0.
- Reset mid-scan discards all samples. No `valid` is produced.
- Let E0 be the edge at which `start` is accepted. Slot k (k=0..3) occupies the cycles after edges E0+k·DWELL .. E0+(k+1)·DWELL-1.
- Sample k is taken at edge E0+(k+1)·DWELL.
- `data`/`valid` update at edge E0+4·DWELL. `valid` is high for exactly one cycle.
- Single mode: `busy` falls at E0+4·DWELL.
- Continuous mode: the next `valid` strobes follow every 4·DWELL cycles.
- The mux is combinational. `din` must be stable by the sampling edge, so DWELL=1 is legal.

## Structure
- Shared package: state encoding (`ST_IDLE`, `ST_SCAN`), constant `NSLOT`=4, select width 2.
- One sub-module is natural: `dwell_counter`, a CW-bit counter with clear and terminal-count output `tc` (`cnt`==DWELL-1).
- The FSM, `shreg` and output registers stay in the top module.

## Test plan
- Single scan, DWELL=4, mux inputs in=4'b1010, `start` pulse: `sel` sequence is 0×4,1×4,2×4,3×4; `valid` is high once, 16 cycles after E0, with `data`=4'b1010; `busy` is high for 16 cycles.
- DWELL=1, in=4'b0110: `valid` 4 cycles after E0, `data`=4'b0110, `sel` changes every cycle.
- Continuous, DWELL=2, in changes from 4'b0011 to 4'b1100 between scans: `valid` at E0+8 with 4'b0011 and at E0+16 with 4'b1100. `stop` asserted at E0+10 means the scan finishes at E0+16, then `busy`=0 and `sel`=0.
- `start` re-pulsed at E0+3 during a single scan: ignored; exactly one `valid`, and `busy` falls at E0+16.
- `rst` pulsed at E0+6 in single mode with DWELL=4: all outputs 0 immediately; no `valid` for 40 cycles afterwards; `data` stays 0.
- `din` toggled mid-slot (valid only on the last cycle of the slot), in=4'b1111 at the sampling edges, 4'b0000 otherwise: `data`=4'b1111.

Source files
------------

// File: rtl/sel_scanner_pkg.sv
// Shared types and constants for the 4:1 select-mux scanner.
// Holds the FSM encoding, the slot count and the select width.
package sel_scanner_pkg;

    localparam int NSLOT = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic is_last_slot(input sel_t s);
        return s == sel_t'(NSLOT - 1);
    endfunction

endpackage

// File: rtl/sel_scanner_dwell_counter.sv
// Per-slot dwell counter: counts 0..DWELL-1 while enabled and flags the
// terminal count so the scanner knows when to sample and advance.
module dwell_counter #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sel_scanner.sv
// Drives the 4:1 mux select through all four inputs, samples the mux output
// at the end of each dwell slot and publishes the assembled word with a strobe.
module sel_scanner
    import sel_scanner_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       stop,
    input  logic       din,
    output logic [1:0] sel,
    output logic [3:0] data,
    output logic       valid,
    output logic       busy
);

    state_t     state_q;
    sel_t       sel_q;
    logic [3:0] data_q;
    logic       valid_q;
    logic       busy_q;
    logic [2:0] shreg_q;
    logic       cont_q;
    logic       stop_q;

    logic tc;
    logic cnt_clr;
    logic cnt_en;
    logic stop_seen;

    assign cnt_clr   = (state_q == ST_IDLE);
    assign cnt_en    = (state_q == ST_SCAN);
    // A stop arriving on the very last cycle of a scan still ends continuous mode.
    assign stop_seen = stop_q | stop;

    dwell_counter #(
        .DWELL (DWELL),
        .CW    (CW)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            shreg_q <= '0;
            cont_q  <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    sel_q  <= '0;
                    stop_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_SCAN;
                        busy_q  <= 1'b1;
                        cont_q  <= cont;
                    end
                end
                ST_SCAN: begin
                    if (stop) begin
                        stop_q <= 1'b1;
                    end
                    if (tc) begin
                        sel_q <= sel_q + 1'b1;
                        case (sel_q)
                            2'd0: shreg_q[0] <= din;
                            2'd1: shreg_q[1] <= din;
                            2'd2: shreg_q[2] <= din;
                            default: begin
                                // Final sample bypasses the shift register straight into the word.
                                data_q  <= {din, shreg_q};
                                valid_q <= 1'b1;
                                if (!(cont_q && !stop_seen)) begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                    stop_q  <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sel   = sel_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;

    always_comb begin
        if (is_last_slot(sel_q) && !busy_q && state_q == ST_SCAN) begin
        end
    end

endmodule

// File: tb/tb_sel_scanner.sv
// Bench for sel_scanner: three instances (DWELL 4, 1, 2) each driving its own
// modelled 4:1 mux, checked cycle by cycle against a timeline reference model.
module tb_sel_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [3];
    logic       start_s [3];
    logic       cont_s  [3];
    logic       stop_s  [3];
    logic       din_s   [3];
    logic [1:0] sel_s   [3];
    logic [3:0] data_s  [3];
    logic       valid_s [3];
    logic       busy_s  [3];
    logic [3:0] in_s    [3];

    logic [3:0] model_data [3];

    int vectors     = 0;
    int miscompares = 0;

    assign din_s[0] = in_s[0][sel_s[0]];
    assign din_s[1] = in_s[1][sel_s[1]];
    assign din_s[2] = in_s[2][sel_s[2]];

    sel_scanner #(.DWELL(4), .CW(8)) u_d4 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .cont(cont_s[0]), .stop(stop_s[0]),
        .din(din_s[0]), .sel(sel_s[0]), .data(data_s[0]), .valid(valid_s[0]), .busy(busy_s[0])
    );

    sel_scanner #(.DWELL(1), .CW(8)) u_d1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .cont(cont_s[1]), .stop(stop_s[1]),
        .din(din_s[1]), .sel(sel_s[1]), .data(data_s[1]), .valid(valid_s[1]), .busy(busy_s[1])
    );

    sel_scanner #(.DWELL(2), .CW(8)) u_d2 (
        .clk(clk), .rst(rst_s[2]), .start(start_s[2]), .cont(cont_s[2]), .stop(stop_s[2]),
        .din(din_s[2]), .sel(sel_s[2]), .data(data_s[2]), .valid(valid_s[2]), .busy(busy_s[2])
    );

    function automatic int dwell_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 2;
    endfunction

    task automatic test_reset();
        logic [7:0] obs;
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1; start_s[i] = 1'b0; cont_s[i] = 1'b0; stop_s[i] = 1'b0;
            in_s[i] = 4'b0000; model_data[i] = 4'b0000;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            obs = {sel_s[i], busy_s[i], valid_s[i], data_s[i]};
            vectors++;
            if (obs !== 8'h00) begin
                miscompares++;
                $display("FAIL reset inst%0d: sel/busy/valid/data got %b required 00000000", i, obs);
            end
            rst_s[i] = 1'b0;
        end
        @(negedge clk);
    endtask

    // Single scan; restart_t is the edge offset from E0 at which start is re-asserted (-1 none).
    task automatic run_single(input int i, input logic [3:0] pat, input bit toggle,
                              input int restart_t, input string tag);
        int d;
        logic [1:0] e_sel;
        logic [3:0] e_data;
        logic [7:0] obs, exp;
        d = dwell_of(i);
        @(negedge clk);
        obs = {sel_s[i], busy_s[i], valid_s[i], data_s[i]};
        exp = {2'b00, 1'b0, 1'b0, model_data[i]};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s idle inst%0d: got %b required %b", tag, i, obs, exp);
        end
        in_s[i] = toggle ? 4'b0000 : pat;
        cont_s[i] = 1'b0;
        start_s[i] = 1'b1;
        for (int t = 0; t <= 4 * d + 2; t++) begin
            @(negedge clk);
            e_sel  = (t < 4 * d) ? 2'(t / d) : 2'b00;
            e_data = (t >= 4 * d) ? pat : model_data[i];
            exp = {e_sel, (t < 4 * d), (t == 4 * d), e_data};
            obs = {sel_s[i], busy_s[i], valid_s[i], data_s[i]};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s inst%0d t=%0d: sel/busy/valid/data got %b required %b",
                         tag, i, t, obs, exp);
            end
            start_s[i] = (t + 1 == restart_t);
            if (toggle) in_s[i] = ((t + 1) % d == 0) ? pat : 4'b0000;
        end
        start_s[i] = 1'b0;
        model_data[i] = pat;
    endtask

    // Continuous scan; stop is high at edge E0+st, so the number of scans is ceil(st/(4*d)).
    task automatic run_cont(input int i, input logic [3:0] pats [4], input int st, input string tag);
        int d, n, len, done, si;
        logic [1:0] e_sel;
        logic [3:0] e_data;
        logic       e_busy, e_valid;
        logic [7:0] obs, exp;
        d   = dwell_of(i);
        n   = (st + 4 * d - 1) / (4 * d);
        len = 4 * d * n;
        @(negedge clk);
        in_s[i] = pats[0];
        cont_s[i] = 1'b1;
        start_s[i] = 1'b1;
        for (int t = 0; t <= len + 2; t++) begin
            @(negedge clk);
            e_busy  = (t < len);
            e_sel   = e_busy ? 2'((t % (4 * d)) / d) : 2'b00;
            e_valid = (t > 0) && (t % (4 * d) == 0) && (t <= len);
            done = t / (4 * d);
            if (done > n) done = n;
            e_data = (done == 0) ? model_data[i] : pats[done - 1];
            exp = {e_sel, e_busy, e_valid, e_data};
            obs = {sel_s[i], busy_s[i], valid_s[i], data_s[i]};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s inst%0d t=%0d: sel/busy/valid/data got %b required %b",
                         tag, i, t, obs, exp);
            end
            start_s[i] = 1'b0;
            cont_s[i]  = 1'b0;
            stop_s[i]  = (t + 1 == st);
            si = t / (4 * d);
            if (si > 3) si = 3;
            in_s[i] = pats[si];
        end
        stop_s[i] = 1'b0;
        model_data[i] = pats[n - 1];
    endtask

    task automatic test_single();
        run_single(0, 4'b1010, 1'b0, -1, "single_d4");
    endtask

    task automatic test_dwell1();
        run_single(1, 4'b0110, 1'b0, -1, "dwell1");
    endtask

    task automatic test_cont();
        logic [3:0] p [4];
        p = '{4'b0011, 4'b1100, 4'b0000, 4'b0000};
        run_cont(2, p, 10, "cont_d2");
    endtask

    task automatic test_restart();
        run_single(0, 4'b0101, 1'b0, 3, "restart_mid");
        run_single(0, 4'b1001, 1'b0, 16, "start_at_end");
    endtask

    task automatic test_toggle();
        run_single(0, 4'b1111, 1'b1, -1, "toggle_d4");
        run_single(2, 4'b1111, 1'b1, -1, "toggle_d2");
    endtask

    task automatic test_random();
        logic [3:0] p [4];
        int i, d, r;
        for (int k = 0; k < 12; k++) begin
            i = $urandom_range(0, 2);
            d = dwell_of(i);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 4; j++) p[j] = 4'($urandom);
                run_cont(i, p, $urandom_range(1, 12 * d), "rand_cont");
            end else begin
                r = $urandom_range(0, 2);
                run_single(i, 4'($urandom), 1'b0,
                           (r == 0) ? -1 : (r == 1) ? int'($urandom_range(1, 4 * d - 1)) : 4 * d,
                           "rand_single");
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] obs, exp;
        @(negedge clk);
        in_s[0] = 4'b1101;
        cont_s[0] = 1'b0;
        start_s[0] = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
            exp = {2'(t / 4), 1'b1, 1'b0, model_data[0]};
            obs = {sel_s[0], busy_s[0], valid_s[0], data_s[0]};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL rst_mid pre t=%0d: got %b required %b", t, obs, exp);
            end
        end
        @(negedge clk);
        rst_s[0] = 1'b1;
        #1;
        obs = {sel_s[0], busy_s[0], valid_s[0], data_s[0]};
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_mid immediate: got %b required 00000000", obs);
        end
        @(negedge clk);
        rst_s[0] = 1'b0;
        model_data[0] = 4'b0000;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            obs = {sel_s[0], busy_s[0], valid_s[0], data_s[0]};
            vectors++;
            if (obs !== 8'h00) begin
                miscompares++;
                $display("FAIL rst_mid after t=%0d: got %b required 00000000", t, obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dwell1();
        test_cont();
        test_restart();
        test_toggle();
        test_random();
        test_reset_mid();
        run_single(0, 4'b0111, 1'b0, -1, "post_rst");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
